// File: rtl/mac_round_sat_if.sv
// Bus between the multiplier-side driver and the round/saturate MAC stage.
// Carries the product stream with its burst framing strobes, and returns
// the sample strobe together with the status flags.
interface mac_round_sat_if #(
  parameter int P_W   = 60,
  parameter int OUT_W = 24
);
  logic signed [P_W-1:0]   p_in;
  logic                    p_valid;
  logic                    p_first;
  logic                    p_last;
  logic                    err_clr;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    busy;
  logic                    sat_flag;
  logic                    err_seq;
  logic                    err_ovf;

  modport master (
    output p_in, p_valid, p_first, p_last, err_clr,
    input  out_data, out_valid, busy, sat_flag, err_seq, err_ovf
  );

  modport slave (
    input  p_in, p_valid, p_first, p_last, err_clr,
    output out_data, out_valid, busy, sat_flag, err_seq, err_ovf
  );
endinterface

// File: rtl/mac_round_sat.sv
// Accumulates one burst of signed products, rounds half-up, shifts and
// saturates the sum to the DAC sample width. Emits one sample per burst
// with a single-cycle strobe; keeps sticky saturation/protocol/overflow flags.
module mac_round_sat #(
  parameter int P_W       = 60,
  parameter int ACC_W     = 64,
  parameter int OUT_W     = 24,
  parameter int SHIFT     = 35,
  parameter int MAX_TERMS = 16
) (
  input logic            pclk,
  input logic            reset_n,
  mac_round_sat_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  // Constants at ACC_W+1 bits so the rounding add cannot wrap.
  localparam logic signed [ACC_W:0] C_HALF =
    {{(ACC_W + 1 - SHIFT){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};
  localparam logic signed [ACC_W:0] C_MAX =
    {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] C_MIN =
    {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic signed [OUT_W-1:0] C_OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
  localparam logic signed [OUT_W-1:0] C_OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

  typedef enum logic {IDLE, ACC} state_t;

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_count;
  logic signed [OUT_W-1:0] r_outData;
  logic                    r_outValid;
  logic                    r_satFlag;
  logic                    r_errSeq;
  logic                    r_errOvf;

  state_t                  w_stateNext;
  logic signed [ACC_W-1:0] w_pExt;
  logic signed [ACC_W-1:0] w_sum;
  logic [CNT_W-1:0]        w_countNext;
  logic                    w_done;
  logic                    w_seqErr;
  logic                    w_ovfErr;
  logic signed [ACC_W:0]   w_sumExt;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_r;
  logic                    w_satHi;
  logic                    w_satLo;
  logic signed [OUT_W-1:0] w_outNext;

  assign w_pExt = {{(ACC_W - P_W){bus.p_in[P_W-1]}}, bus.p_in};

  // Next state, next accumulator value and event strobes for this beat;
  // w_sum is the value the accumulator takes, which is also the burst sum on p_last.
  always_comb begin
    w_stateNext = r_state;
    w_sum       = r_acc;
    w_countNext = r_count;
    w_done      = 1'b0;
    w_seqErr    = 1'b0;
    w_ovfErr    = 1'b0;
    if (bus.p_valid) begin
      if (bus.p_first) begin
        w_sum       = w_pExt;
        w_countNext = CNT_W'(1);
        w_stateNext = ACC;
        w_seqErr    = (r_state == ACC);
        if (bus.p_last) begin
          w_done      = 1'b1;
          w_stateNext = IDLE;
        end
      end else if (r_state == IDLE) begin
        w_seqErr = 1'b1;
      end else begin
        if (r_count < CNT_W'(MAX_TERMS)) begin
          w_sum       = r_acc + w_pExt;
          w_countNext = r_count + CNT_W'(1);
        end else begin
          w_ovfErr = 1'b1;
        end
        if (bus.p_last) begin
          w_done      = 1'b1;
          w_stateNext = IDLE;
        end
      end
    end
  end

  // Round half-up, arithmetic shift, then clamp into the sample range.
  always_comb begin
    w_sumExt  = {w_sum[ACC_W-1], w_sum};
    w_rnd     = w_sumExt + C_HALF;
    w_r       = w_rnd >>> SHIFT;
    w_satHi   = (w_r > C_MAX);
    w_satLo   = (w_r < C_MIN);
    w_outNext = w_r[OUT_W-1:0];
    if (w_satHi) begin
      w_outNext = C_OUT_MAX;
    end else if (w_satLo) begin
      w_outNext = C_OUT_MIN;
    end
  end

  // Burst state, accumulator and term count.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_acc   <= w_sum;
      r_count <= w_countNext;
    end
  end

  // Result register and sticky flags; a set condition beats err_clr.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_satFlag  <= 1'b0;
      r_errSeq   <= 1'b0;
      r_errOvf   <= 1'b0;
    end else begin
      r_outValid <= w_done;
      if (w_done) begin
        r_outData <= w_outNext;
      end
      r_satFlag <= (w_done & (w_satHi | w_satLo)) | (r_satFlag & ~bus.err_clr);
      r_errSeq  <= w_seqErr | (r_errSeq & ~bus.err_clr);
      r_errOvf  <= w_ovfErr | (r_errOvf & ~bus.err_clr);
    end
  end

  assign bus.out_data  = r_outData;
  assign bus.out_valid = r_outValid;
  assign bus.busy      = (r_state == ACC);
  assign bus.sat_flag  = r_satFlag;
  assign bus.err_seq   = r_errSeq;
  assign bus.err_ovf   = r_errOvf;

endmodule

// File: tb/tb_mac_round_sat.sv
// Randomised and directed bench for mac_round_sat with a scoreboard queue.
module tb_mac_round_sat;

  localparam longint UNIT = 64'sd1 <<< 35;

  logic pclk;
  logic reset_n;

  mac_round_sat_if #(.P_W(60), .OUT_W(24)) bus ();

  mac_round_sat dut (
    .pclk    (pclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int nTests = 0;
  int nFail  = 0;

  longint expQ[$];

  // Reference model state: the burst as a list of accepted terms.
  bit     mInBurst = 0;
  longint mTerms[$];
  bit     mSat = 0;
  bit     mSeq = 0;
  bit     mOvf = 0;

  // Free-running clock, 10 time units per cycle.
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Guard against a hang anywhere in the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired tests=%0d", nTests);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkEq(input string name, input longint act, input longint exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sum of the burst, rounded half-up by floor division, clamped to 24 bits.
  function automatic longint expResult(output bit sat);
    logic signed [71:0] num;
    logic signed [71:0] den;
    logic signed [71:0] q;
    num = 0;
    foreach (mTerms[i]) num = num + mTerms[i];
    num = num + (UNIT / 2);
    den = UNIT;
    q = num / den;
    if (num < 0 && (num % den) != 0) q = q - 1;
    sat = 1'b0;
    if (q > 8388607) begin
      sat = 1'b1;
      return 64'sd8388607;
    end
    if (q < -8388608) begin
      sat = 1'b1;
      return -64'sd8388608;
    end
    return longint'(q);
  endfunction

  task automatic modelBeat(input bit v, input bit f, input bit l, input longint p, input bit clr);
    bit nSeq, nOvf, nSat, s;
    longint r;
    nSeq = 0; nOvf = 0; nSat = 0;
    if (v) begin
      if (f) begin
        if (mInBurst) nSeq = 1;
        mTerms.delete();
        mTerms.push_back(p);
        mInBurst = 1;
      end else if (!mInBurst) begin
        nSeq = 1;
      end else if (mTerms.size() < 16) begin
        mTerms.push_back(p);
      end else begin
        nOvf = 1;
      end
      if (l && mInBurst) begin
        r = expResult(s);
        expQ.push_back(r);
        nSat = s;
        mInBurst = 0;
      end
    end
    mSat = nSat | (mSat & !clr);
    mSeq = nSeq | (mSeq & !clr);
    mOvf = nOvf | (mOvf & !clr);
  endtask

  task automatic checkOutput();
    checkEq("busy",     longint'(bus.busy),     longint'(mInBurst));
    checkEq("sat_flag", longint'(bus.sat_flag), longint'(mSat));
    checkEq("err_seq",  longint'(bus.err_seq),  longint'(mSeq));
    checkEq("err_ovf",  longint'(bus.err_ovf),  longint'(mOvf));
  endtask

  // Drive one cycle of inputs at the falling edge, check flags just after the rising edge.
  task automatic applyStimulus(input bit v, input bit f, input bit l, input longint p, input bit clr);
    @(negedge pclk);
    bus.p_valid = v;
    bus.p_first = f;
    bus.p_last  = l;
    bus.p_in    = p[59:0];
    bus.err_clr = clr;
    modelBeat(v, f, l, p, clr);
    @(posedge pclk);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  task automatic burstOf(input int n, input longint p);
    for (int i = 0; i < n; i++) applyStimulus(1, i == 0, i == n - 1, p, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkEq({tag, " out_data"},  longint'($signed(bus.out_data)), 0);
    checkEq({tag, " out_valid"}, longint'(bus.out_valid), 0);
    checkEq({tag, " busy"},      longint'(bus.busy), 0);
    checkEq({tag, " sat_flag"},  longint'(bus.sat_flag), 0);
    checkEq({tag, " err_seq"},   longint'(bus.err_seq), 0);
    checkEq({tag, " err_ovf"},   longint'(bus.err_ovf), 0);
  endtask

  function automatic longint randProduct();
    longint raw;
    raw = {$urandom, $urandom};
    raw = raw >>> 4;
    raw = raw >>> $urandom_range(0, 22);
    return raw;
  endfunction

  // Monitor: every sample strobe must match the oldest expected result.
  initial begin
    forever begin
      @(negedge pclk);
      if (reset_n && bus.out_valid) begin
        if (expQ.size() == 0) begin
          checkEq("unexpected out_valid", 1, 0);
        end else begin
          checkEq("out_data", longint'($signed(bus.out_data)), expQ.pop_front());
        end
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    bus.p_valid = 1'b0;
    bus.p_first = 1'b0;
    bus.p_last  = 1'b0;
    bus.p_in    = '0;
    bus.err_clr = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    checkAllZero("reset");
    @(negedge pclk);
    reset_n = 1'b1;

    // Single term and rounding cases
    applyStimulus(1, 1, 1, 100 * UNIT, 0);
    idle(1);
    applyStimulus(1, 1, 1, 5 * UNIT + UNIT / 2, 0);
    applyStimulus(1, 1, 1, -(5 * UNIT) - UNIT / 2, 0);
    applyStimulus(1, 1, 1, 5 * UNIT + UNIT / 2 - 1, 0);
    idle(2);

    // Three terms with idle gaps
    applyStimulus(1, 1, 0, 10 * UNIT, 0);
    idle(2);
    applyStimulus(1, 0, 0, -3 * UNIT, 0);
    idle(1);
    applyStimulus(1, 0, 1, 7 * UNIT, 0);
    idle(2);

    // Saturation high, then 16 and 17 terms at the negative extreme
    burstOf(2, 64'sd1 <<< 58);
    idle(1);
    applyStimulus(0, 0, 0, 0, 1);
    burstOf(16, -(64'sd1 <<< 59));
    idle(1);
    burstOf(17, -(64'sd1 <<< 59));
    idle(1);
    applyStimulus(0, 0, 0, 0, 1);

    // Protocol violations: stray beat, restart mid-burst, clear
    applyStimulus(1, 0, 1, 3 * UNIT, 0);
    idle(1);
    applyStimulus(1, 1, 0, 50 * UNIT, 0);
    applyStimulus(1, 0, 0, 50 * UNIT, 0);
    applyStimulus(1, 1, 0, 2 * UNIT, 0);
    applyStimulus(1, 0, 1, 4 * UNIT, 0);
    applyStimulus(0, 1, 1, 9 * UNIT, 0);
    applyStimulus(0, 0, 0, 0, 1);

    // Reset after two of four terms, then a fresh burst
    applyStimulus(1, 1, 0, 20 * UNIT, 0);
    applyStimulus(1, 0, 0, 20 * UNIT, 0);
    @(negedge pclk);
    bus.p_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkAllZero("mid-burst reset");
    mInBurst = 0; mTerms.delete(); mSat = 0; mSeq = 0; mOvf = 0;
    expQ.delete();
    @(negedge pclk);
    reset_n = 1'b1;
    applyStimulus(1, 1, 1, UNIT, 0);
    idle(2);

    // Randomised bursts with gaps, restarts, stray beats and clears
    for (int b = 0; b < 150; b++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 18) : $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0)
        applyStimulus(1, 0, $urandom_range(0, 1), randProduct(), 0);
      for (int i = 0; i < n; i++) begin
        applyStimulus(1, (i == 0) || ($urandom_range(0, 29) == 0), i == n - 1,
                      randProduct(), $urandom_range(0, 19) == 0);
        if ($urandom_range(0, 3) == 0)
          applyStimulus(0, $urandom_range(0, 1), $urandom_range(0, 1),
                        randProduct(), $urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 1) == 0) idle(1);
    end

    idle(3);
    checkEq("results left unmatched", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
